cordic_issue_master: RTL and testbench

Initiator for the fixed-point CORDIC cosine custom-instruction slave. It buffers IEEE-754 single-precision operands from an upstream valid/ready stream and issues them one at a time over the slave's `clk_en`/`start`/`done` handshake. It captures each result and presents it on a downstream valid/ready stream, with results in the same order as the operands. The block sits between the system datapath and the `cordic` slave, so that datapath logic can use the accelerator without a Nios II core.

---
 rtl/cordic_issue_master.sv | 106 ++++++++++
 tb/tb_cordic_issue_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/cordic_issue_master.sv
// cordic_issue_master: FIFO-buffered issuer for the CORDIC cosine slave; CORDIC_ISSUE_TIMEOUT_EN adds the done-timeout path.
module cordic_issue_master #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 31
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        cordic_aclr,
  output logic        cordic_clk_en,
  output logic        cordic_start,
  output logic [31:0] cordic_dataa,
  input  logic [31:0] cordic_result,
  input  logic        cordic_done,
  output logic        busy,
  output logic        timeout_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, START, RUN, OUT} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [31:0] out_data_q, out_data_d;
  logic aclr_q, aclr_d, push, pop, tmo;
  assign in_ready = count_q != (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state_q == START;
`ifdef CORDIC_ISSUE_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic terr_q, terr_d;
  assign tmo = state_q == RUN && !cordic_done && wait_cnt_q == 8'(TIMEOUT);
  assign timeout_err = terr_q;
  always_comb begin
    wait_cnt_d = state_q == START ? 8'd0 : state_q == RUN ? wait_cnt_q + 8'd1 : wait_cnt_q;
    terr_d = terr_q | tmo;
  end
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wait_cnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      terr_q <= terr_d;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    out_data_d = out_data_q;
    aclr_d = tmo;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    case (state_q)
      IDLE: state_d = count_q != 0 ? START : IDLE;
      START: state_d = RUN;
      RUN: begin
        if (cordic_done) begin
          out_data_d = cordic_result;
          state_d = OUT;
        end else if (tmo) begin
          out_data_d = 32'h7FC0_0000;
          state_d = OUT;
        end
      end
      default: if (out_ready) state_d = count_q != 0 ? START : IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_data_q <= '0;
      aclr_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      out_data_q <= out_data_d;
      aclr_q <= aclr_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end
  // The slave's index freezes once done is seen, so clk_en drops in the done cycle itself.
  assign cordic_clk_en = state_q == START || (state_q == RUN && !cordic_done);
  assign cordic_start = state_q == START;
  assign cordic_dataa = count_q != 0 ? mem_q[rd_ptr_q] : 32'd0;
  assign cordic_aclr = aclr_q;
  assign out_valid = state_q == OUT;
  assign out_data = out_data_q;
  assign busy = count_q != 0 || state_q != IDLE;
endmodule

// File: tb/tb_cordic_issue_master.sv
// tb_cordic_issue_master: directed bench with a 3-step slave model and an in-order result scoreboard.
module tb_cordic_issue_master;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 31;
  logic clock = 0, aclr_n = 1, in_valid = 0, out_ready = 0, kill_done = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, cordic_aclr, cordic_clk_en, cordic_start, cordic_done, busy, timeout_err;
  logic [31:0] out_data, cordic_dataa, cordic_result;
  logic [1:0] idx = 0;
  logic [31:0] sl_a = 0;
  int vecs = 0, errs = 0;
  logic [31:0] exp_q [$];
  always #5 clock = ~clock;
  cordic_issue_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cordic_aclr(cordic_aclr),
    .cordic_clk_en(cordic_clk_en), .cordic_start(cordic_start), .cordic_dataa(cordic_dataa),
    .cordic_result(cordic_result), .cordic_done(cordic_done), .busy(busy), .timeout_err(timeout_err));
  function automatic logic [31:0] f(input logic [31:0] x);
    return x == 32'h3F80_0000 ? 32'h3F0A_5140 : x ^ 32'h3F80_0000;
  endfunction
  always @(posedge clock)
    if (cordic_aclr) idx <= 0;
    else if (cordic_clk_en && cordic_start) begin
      idx <= 1;
      sl_a <= cordic_dataa;
    end else if (cordic_clk_en && idx != 0 && idx != 3) idx <= idx + 1;
  assign cordic_done = idx == 3 && !kill_done;
  assign cordic_result = f(sl_a);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clock)
    if (aclr_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_result", 32'(exp_q.size()), 32'd1);
      else chk("result", out_data, exp_q.pop_front());
    end
  task automatic push(input logic [31:0] d, input logic [31:0] e, output bit acc);
    in_valid = 1;
    in_data = d;
    acc = in_ready;
    if (acc) exp_q.push_back(e);
    @(posedge clock);
    #1 in_valid = 0;
  endtask
  task automatic wait_out(output int c, output int starts);
    c = 0;
    starts = 0;
    while (!out_valid && c < 80) begin
      @(posedge clock);
      #1 c++;
      if (cordic_start) starts++;
      if (cordic_done && !cordic_start) chk("done_clk_en", cordic_clk_en, 0);
    end
  endtask
  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 300) begin
      @(posedge clock);
      #1 c++;
    end
    chk(tag, busy, 0);
    chk({tag, "_queue"}, 32'(exp_q.size()), 0);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_start"}, cordic_start, 0);
    chk({tag, "_clk_en"}, cordic_clk_en, 0);
    chk({tag, "_aclr"}, cordic_aclr, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask
  initial begin
    bit acc;
    int c, starts, bad, n;
    out_ready = 1;
    #1 aclr_n = 0;
    #11 chk_reset("rst");
    #4 aclr_n = 1;
    #4 chk("aclr_hold", cordic_aclr, 1);
    @(posedge clock);
    #1 chk("aclr_release", cordic_aclr, 0);
    push(32'h0, 32'h3F80_0000, acc);
    wait_out(c, starts);
    chk("single_latency", 32'(c), 5);
    chk("single_starts", 32'(starts), 1);
    chk("dataa_empty", cordic_dataa, 0);
    wait_idle("single_idle");
    out_ready = 0;
    push(32'h3F80_0000, 32'h3F0A_5140, acc);
    wait_out(c, starts);
    chk("bp_latency", 32'(c), 5);
    push(32'h4049_0FDB, f(32'h4049_0FDB), acc);
    bad = 0;
    repeat (10) begin
      @(posedge clock);
      #1 if (out_data !== 32'h3F0A_5140 || cordic_clk_en || cordic_start || !out_valid) bad++;
    end
    chk("bp_hold", 32'(bad), 0);
    chk("bp_dataa_head", cordic_dataa, 32'h4049_0FDB);
    out_ready = 1;
    wait_idle("bp_drain");
    out_ready = 0;
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(32'h3E00_0000 + 32'(i), f(32'h3E00_0000 + 32'(i)), acc);
      n += int'(acc);
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_accepted", 32'(n), DEPTH + 1);
    out_ready = 1;
    wait_idle("full_drain");
`ifdef CORDIC_ISSUE_TIMEOUT_EN
    kill_done = 1;
    push(32'h0, 32'h7FC0_0000, acc);
    n = 0;
    c = 0;
    while (!out_valid && c < TIMEOUT + 20) begin
      @(posedge clock);
      #1 c++;
      if (cordic_aclr) n++;
    end
    chk("to_out_valid", out_valid, 1);
    repeat (3) begin
      @(posedge clock);
      #1 if (cordic_aclr) n++;
    end
    chk("to_aclr_pulses", 32'(n), 1);
    chk("to_err", timeout_err, 1);
    kill_done = 0;
    wait_idle("to_idle");
    push(32'h0, 32'h3F80_0000, acc);
    wait_idle("to_recover");
    chk("to_err_sticky", timeout_err, 1);
`endif
    push(32'h0, 32'h3F80_0000, acc);
    push(32'h3F80_0000, 32'h3F0A_5140, acc);
    push(32'h0, 32'h3F80_0000, acc);
    c = 0;
    while (!(cordic_clk_en && !cordic_start) && c < 20) begin
      @(posedge clock);
      #1 c++;
    end
    chk("mid_in_run", cordic_clk_en, 1);
    #2 aclr_n = 0;
    #1 chk_reset("mid_rst");
    exp_q.delete();
    @(posedge clock);
    #1 aclr_n = 1;
    @(posedge clock);
    #1 push(32'h0, 32'h3F80_0000, acc);
    wait_out(c, starts);
    chk("post_rst_latency", 32'(c), 5);
    wait_idle("post_rst_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
